// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_uart_loader
// Description : Serial program loader for the single-cycle core. Receives a
//               program image over UART 8N1 (0xA5, N_lo, N_hi, 4*N payload
//               bytes, little-endian words), writes it into the instruction
//               memory write port and holds the core in reset until a
//               complete, valid image is present.
//               Optional macro LOADER_CHKSUM_EN appends an XOR checksum byte
//               over the payload and enables the CSUM state.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_uart_loader #(
    parameter int CLK_HZ      = 10_000_000,
    parameter int BAUD        = 115_200,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int c_DIV  = CLK_HZ / BAUD;
    localparam int c_HALF = c_DIV / 2;
    localparam int c_CW   = $clog2(c_DIV + 1);
    localparam logic [c_CW-1:0] c_DIV_M1  = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(c_HALF - 1);
    localparam logic [16:0]     c_DEPTH   = 17'(DEPTH_WORDS);
    localparam logic [7:0]      c_SYNC    = 8'hA5;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

    uart_state_t     r_ustate, w_ustate_nx;
    logic            r_rx_s1, r_rx_s2, r_rx_prev;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_cnt_clr;
    logic            w_byte_valid;
    logic            w_frame_err;
    logic            w_half_hit;
    logic            w_full_hit;
    logic [7:0]      w_byte;

    assign w_half_hit = (r_cnt == c_HALF_M1);
    assign w_full_hit = (r_cnt == c_DIV_M1);
    assign w_byte     = r_shift;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx_i;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Receiver state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_ustate <= U_IDLE;
        else        r_ustate <= w_ustate_nx;
    end

    // Receiver next state, bit-timer restart and byte/error strobes
    always_comb begin
        w_ustate_nx  = r_ustate;
        w_cnt_clr    = 1'b0;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        case (r_ustate)
            U_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_ustate_nx = U_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            U_START: begin
                // Mid-start-bit re-check rejects short glitches
                if (w_half_hit) begin
                    w_cnt_clr   = 1'b1;
                    w_ustate_nx = r_rx_s2 ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (w_full_hit) begin
                    w_cnt_clr = 1'b1;
                    if (r_bit == 3'd7) w_ustate_nx = U_STOP;
                end
            end
            U_STOP: begin
                if (w_full_hit) begin
                    w_cnt_clr   = 1'b1;
                    w_ustate_nx = U_IDLE;
                    if (r_rx_s2) w_byte_valid = 1'b1;
                    else         w_frame_err  = 1'b1;
                end
            end
            default: w_ustate_nx = U_IDLE;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_ustate == U_START) r_bit <= 3'd0;
            if (r_ustate == U_DATA && w_full_hit) begin
                r_shift <= {r_rx_s2, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
`ifdef LOADER_CHKSUM_EN
        S_CSUM  = 3'd5,
`endif
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } load_state_t;

`ifdef LOADER_CHKSUM_EN
    localparam load_state_t c_END_STATE = S_CSUM;
`else
    localparam load_state_t c_END_STATE = S_DONE;
`endif

    load_state_t r_state, w_state_nx;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_word;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] w_len_in;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_len_in = {w_byte, r_len[7:0]};

    // Loader state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Loader next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_byte_valid && w_byte == c_SYNC) w_state_nx = S_LEN0;
            end
            S_LEN0: begin
                if (w_frame_err)       w_state_nx = S_ERR;
                else if (w_byte_valid) w_state_nx = S_LEN1;
            end
            S_LEN1: begin
                if (w_frame_err) begin
                    w_state_nx = S_ERR;
                end else if (w_byte_valid) begin
                    if ({1'b0, w_len_in} > c_DEPTH) w_state_nx = S_ERR;
                    else if (w_len_in == 16'd0)     w_state_nx = c_END_STATE;
                    else                            w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_frame_err)                         w_state_nx = S_ERR;
                else if (w_byte_valid && r_bcnt == 2'd3) w_state_nx = S_WRITE;
            end
            S_WRITE: begin
                // The strobe cycle; decide whether that was the last word
                if (w_frame_err)                    w_state_nx = S_ERR;
                else if (r_idx == r_len - 16'd1)    w_state_nx = c_END_STATE;
                else                                w_state_nx = S_DATA;
            end
`ifdef LOADER_CHKSUM_EN
            S_CSUM: begin
                if (w_frame_err)       w_state_nx = S_ERR;
                else if (w_byte_valid) w_state_nx = (w_byte == r_csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (w_byte_valid && w_byte == c_SYNC) w_state_nx = S_LEN0;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Length capture, word assembly, write address/data and word index
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_len   <= 16'd0;
            r_idx   <= 16'd0;
            r_bcnt  <= 2'd0;
            r_word  <= 24'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_LEN0: begin
                    if (w_byte_valid) begin
                        r_len[7:0] <= w_byte;
                        r_idx      <= 16'd0;
                        r_bcnt     <= 2'd0;
                    end
                end
                S_LEN1: begin
                    if (w_byte_valid) r_len[15:8] <= w_byte;
                end
                S_DATA: begin
                    if (w_byte_valid) begin
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_addr  <= {14'd0, r_idx, 2'b00};
                            r_wdata <= {w_byte, r_word};
                        end else begin
                            r_word <= {w_byte, r_word[23:8]};
                        end
                    end
                end
                S_WRITE: r_idx <= r_idx + 16'd1;
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHKSUM_EN
    // Running XOR over payload bytes only
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_csum <= 8'd0;
        end else if (r_state == S_LEN0 && w_byte_valid) begin
            r_csum <= 8'd0;
        end else if (r_state == S_DATA && w_byte_valid) begin
            r_csum <= r_csum ^ w_byte;
        end
    end
`endif

    assign imem_we_o    = (r_state == S_WRITE);
    assign imem_addr_o  = r_addr;
    assign imem_wdata_o = r_wdata;
    assign done_o       = (r_state == S_DONE);
    assign err_o        = (r_state == S_ERR);
    assign core_rst_o   = (r_state != S_DONE);
`ifdef LOADER_CHKSUM_EN
    assign busy_o = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA) ||
                    (r_state == S_WRITE) || (r_state == S_CSUM);
`else
    assign busy_o = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA) ||
                    (r_state == S_WRITE);
`endif

endmodule
`default_nettype wire
